// File: rtl/param_priority_encoder_rr_if.sv
// Purpose : request/result stream bundle for param_priority_encoder_rr.
// Signals : in_vld/in_rdy/req/mode  - request side (producer -> encoder)
//           out_vld/out_rdy/idx/hit/onehot - result side (encoder -> consumer)
// Modports: master = producer/consumer environment, slave = encoder.
interface param_priority_encoder_rr_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N <= 2) ? 1 : $clog2(N)
);
    logic         in_vld;
    logic         in_rdy;
    logic [N-1:0] req;
    logic         mode;
    logic         out_vld;
    logic         out_rdy;
    logic [W-1:0] idx;
    logic         hit;
    logic [N-1:0] onehot;

    modport master (
        output in_vld, req, mode, out_rdy,
        input  in_rdy, out_vld, idx, hit, onehot
    );

    modport slave (
        input  in_vld, req, mode, out_rdy,
        output in_rdy, out_vld, idx, hit, onehot
    );
endinterface

// File: rtl/param_priority_encoder_rr.sv
// Purpose : N-input priority encoder with a registered, valid/ready result.
//           mode=0 picks the highest set bit; mode=1 searches upward from a
//           rotating pointer that moves past each round-robin winner.
// Ports   : clk    - clock, all state on posedge
//           rst    - synchronous active-high reset
//           enc_if - slave modport of param_priority_encoder_rr_if
//                    (in_vld/in_rdy/req/mode in, out_vld/out_rdy/idx/hit/onehot out)
module param_priority_encoder_rr #(
    parameter int unsigned N = 8,
    parameter int unsigned W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic                         clk,
    input  logic                         rst,
    param_priority_encoder_rr_if.slave   enc_if
);

    // Result and pointer registers
    logic         out_vld_q, out_vld_d;
    logic [W-1:0] idx_q,     idx_d;
    logic         hit_q,     hit_d;
    logic [N-1:0] onehot_q,  onehot_d;
    logic [W-1:0] ptr_q,     ptr_d;

    // Candidate winners for both modes
    logic [W-1:0] fix_idx;
    logic         fix_hit;
    logic [W-1:0] rr_idx;
    logic         rr_hit;

    logic         in_rdy_c;
    logic         accept_c;
    logic [W-1:0] win_idx_c;
    logic         win_hit_c;

    // Accept whenever the output register is empty or being drained this cycle
    assign in_rdy_c = !out_vld_q || enc_if.out_rdy;
    assign accept_c = enc_if.in_vld && in_rdy_c;

    // Fixed priority: later (higher) set bits overwrite earlier ones
    always_comb begin
        fix_idx = '0;
        fix_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (enc_if.req[i]) begin
                fix_idx = W'(i);
                fix_hit = 1'b1;
            end
        end
    end

    // Round robin: scan ptr, ptr+1, ... wrapping at N (explicit, N need not be 2^k)
    always_comb begin
        int unsigned pos;
        rr_idx = '0;
        rr_hit = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_q) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!rr_hit && enc_if.req[W'(pos)]) begin
                rr_idx = W'(pos);
                rr_hit = 1'b1;
            end
        end
    end

    assign win_idx_c = enc_if.mode ? rr_idx : fix_idx;
    assign win_hit_c = enc_if.mode ? rr_hit : fix_hit;

    // Next-state: load on accept, drop valid on a pure drain, otherwise hold
    always_comb begin
        out_vld_d = out_vld_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        onehot_d  = onehot_q;
        ptr_d     = ptr_q;

        if (accept_c) begin
            out_vld_d = 1'b1;
            idx_d     = win_idx_c;
            hit_d     = win_hit_c;
            onehot_d  = win_hit_c ? (N'(1) << win_idx_c) : '0;
            // Only a round-robin hit advances the pointer
            if (enc_if.mode && rr_hit) begin
                if (32'(rr_idx) + 1 >= N) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = W'(32'(rr_idx) + 1);
                end
            end
        end else if (enc_if.out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            onehot_q  <= '0;
            ptr_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            onehot_q  <= onehot_d;
            ptr_q     <= ptr_d;
        end
    end

    assign enc_if.in_rdy  = in_rdy_c;
    assign enc_if.out_vld = out_vld_q;
    assign enc_if.idx     = idx_q;
    assign enc_if.hit     = hit_q;
    assign enc_if.onehot  = onehot_q;

endmodule

// File: tb/tb_param_priority_encoder_rr.sv
// Purpose : directed, table-driven check of param_priority_encoder_rr (N=8).
module tb_param_priority_encoder_rr;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic clk;
    logic rst;

    param_priority_encoder_rr_if #(.N(N), .W(W)) bus_if ();

    param_priority_encoder_rr #(.N(N), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .enc_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         vld;
        logic         mode;
        logic [N-1:0] req;
        logic         ordy;
        logic         exp_rdy;   // in_rdy before the edge
        logic         exp_vld;   // out_vld after the edge
        logic         chk_data;  // compare idx/hit/onehot after the edge
        logic [W-1:0] exp_idx;
        logic         exp_hit;
        logic [N-1:0] exp_oh;
    } vec_t;

    vec_t tbl[$];
    int   checks;
    int   errors;

    function automatic vec_t mk(logic r, logic vl, logic md, logic [N-1:0] rq, logic ordy,
                                logic erdy, logic evld, logic cd, logic [W-1:0] eidx,
                                logic ehit, logic [N-1:0] eoh);
        vec_t v;
        v.rst = r; v.vld = vl; v.mode = md; v.req = rq; v.ordy = ordy;
        v.exp_rdy = erdy; v.exp_vld = evld; v.chk_data = cd;
        v.exp_idx = eidx; v.exp_hit = ehit; v.exp_oh = eoh;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        rst           = v.rst;
        bus_if.in_vld = v.vld;
        bus_if.mode   = v.mode;
        bus_if.req    = v.req;
        bus_if.out_rdy = v.ordy;
        #1;
        check({tag, ".in_rdy"}, 32'(bus_if.in_rdy), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        check({tag, ".out_vld"}, 32'(bus_if.out_vld), 32'(v.exp_vld));
        if (v.chk_data) begin
            check({tag, ".idx"},    32'(bus_if.idx),    32'(v.exp_idx));
            check({tag, ".hit"},    32'(bus_if.hit),    32'(v.exp_hit));
            check({tag, ".onehot"}, 32'(bus_if.onehot), 32'(v.exp_oh));
        end
        if (bus_if.out_vld) begin
            check({tag, ".inv_hit"}, 32'(bus_if.hit), 32'(|bus_if.onehot));
        end
    endtask

    initial begin
        logic [N-1:0] oh;
        checks = 0;
        errors = 0;

        // fixed priority, then no-request
        tbl.push_back(mk(0,1,0,8'b0010_1100,1, 1,1,1, 3'd5,1,8'h20));
        tbl.push_back(mk(0,1,0,8'h00,       1, 1,1,1, 3'd0,0,8'h00));
        // nine back-to-back round-robin accepts of all-ones: 0..7 then wrap to 0
        for (int i = 0; i < 9; i++) begin
            oh = 8'(1) << (i % 8);
            tbl.push_back(mk(0,1,1,8'hFF,1, 1,1,1, 3'(i % 8),1,oh));
        end
        // ptr=1: bit5 wins, ptr->6
        tbl.push_back(mk(0,1,1,8'h20,1, 1,1,1, 3'd5,1,8'h20));
        // ptr=6 with req 0000_0101: wraps to 0, ptr->1; again gives 2, ptr->3
        tbl.push_back(mk(0,1,1,8'h05,1, 1,1,1, 3'd0,1,8'h01));
        tbl.push_back(mk(0,1,1,8'h05,1, 1,1,1, 3'd2,1,8'h04));
        // fixed mode leaves ptr=3 alone
        tbl.push_back(mk(0,1,0,8'h05,1, 1,1,1, 3'd2,1,8'h04));
        tbl.push_back(mk(0,1,1,8'h09,1, 1,1,1, 3'd3,1,8'h08));   // ptr->4
        // backpressure for three cycles: no accept, result held
        tbl.push_back(mk(0,0,1,8'hFF,0, 0,1,1, 3'd3,1,8'h08));
        tbl.push_back(mk(0,1,1,8'hFF,0, 0,1,1, 3'd3,1,8'h08));
        tbl.push_back(mk(0,1,1,8'hFF,0, 0,1,1, 3'd3,1,8'h08));
        // release together with a new request: reload, valid stays up, ptr->5
        tbl.push_back(mk(0,1,1,8'hFF,1, 1,1,1, 3'd4,1,8'h10));
        // drain with nothing new: valid falls
        tbl.push_back(mk(0,0,1,8'hFF,1, 1,0,0, 3'd0,0,8'h00));
        tbl.push_back(mk(0,0,1,8'hFF,0, 1,0,0, 3'd0,0,8'h00));
        // ptr=5, req bit0 only: wraps to 0, ptr->1; then held by backpressure
        tbl.push_back(mk(0,1,1,8'h01,0, 1,1,1, 3'd0,1,8'h01));
        tbl.push_back(mk(0,1,1,8'hFF,0, 0,1,1, 3'd0,1,8'h01));
        // reset while holding: result discarded, ptr back to 0
        tbl.push_back(mk(1,1,1,8'hFF,0, 0,0,1, 3'd0,0,8'h00));
        // ptr=0 picks bit0 of 0000_0011 (ptr=1 would pick bit1), ptr->1
        tbl.push_back(mk(0,1,1,8'h03,1, 1,1,1, 3'd0,1,8'h01));
        tbl.push_back(mk(0,1,1,8'h80,1, 1,1,1, 3'd7,1,8'h80));   // ptr->0
        tbl.push_back(mk(0,1,1,8'hFF,1, 1,1,1, 3'd0,1,8'h01));

        // reset state
        rst            = 1'b1;
        bus_if.in_vld  = 1'b0;
        bus_if.mode    = 1'b0;
        bus_if.req     = '0;
        bus_if.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_vld", 32'(bus_if.out_vld), 32'd0);
        check("rst.idx",     32'(bus_if.idx),     32'd0);
        check("rst.hit",     32'(bus_if.hit),     32'd0);
        check("rst.onehot",  32'(bus_if.onehot),  32'd0);
        rst = 1'b0;
        #1;
        check("rst.in_rdy",  32'(bus_if.in_rdy),  32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
